// File: rtl/muldiv_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } muldiv_state_e;

  // True when operand A is interpreted as signed; B is signed for these too, except MULHSU.
  function automatic logic is_signed_op(input muldiv_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one shift-add or restoring-subtract step per cycle,
// sharing a single 2*WIDTH accumulator and one WIDTH+1-bit adder/subtractor.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_operandA,
  input  logic [WIDTH-1:0] i_operandB,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  muldiv_state_e      state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  muldiv_op_e         op_q, op_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic [WIDTH-1:0]   data_q, data_d;

  muldiv_op_e         op_in;
  logic               a_sgn, b_sgn;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH-1:0]   min_int;
  logic               div_zero, div_ovf;
  logic [WIDTH-1:0]   special;

  logic               sub;
  logic [WIDTH:0]     add_a, add_b, sum;
  logic [2*WIDTH-1:0] step;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;
  logic [WIDTH-1:0]   fix_res;

  assign o_ready = (state_q == S_IDLE);
  assign o_valid = (state_q == S_DONE);
  assign o_data  = data_q;

  // Operand conditioning at accept
  assign op_in    = muldiv_op_e'(i_op);
  assign a_sgn    = is_signed_op(op_in) && i_operandA[WIDTH-1];
  assign b_sgn    = is_signed_op(op_in) && (op_in != OP_MULHSU) && i_operandB[WIDTH-1];
  assign a_abs    = a_sgn ? (~i_operandA + {{(WIDTH-1){1'b0}}, 1'b1}) : i_operandA;
  assign b_abs    = b_sgn ? (~i_operandB + {{(WIDTH-1){1'b0}}, 1'b1}) : i_operandB;
  assign min_int  = {1'b1, {(WIDTH-1){1'b0}}};
  assign div_zero = op_in[2] && (i_operandB == '0);
  assign div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                    (i_operandA == min_int) && (i_operandB == '1);
  assign special  = div_zero ? (op_in[1] ? i_operandA : '1)
                             : (op_in[1] ? '0 : min_int);

  // Shared adder: mul adds into the upper half, div subtracts from the shifted remainder
  assign sub   = op_q[2];
  assign add_a = sub ? acc_q[2*WIDTH-1:WIDTH-1] : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
  assign add_b = {1'b0, opnd_q};
  assign sum   = add_a + (add_b ^ {(WIDTH+1){sub}}) + {{WIDTH{1'b0}}, sub};

  always_comb begin
    if (!sub) begin
      step = acc_q[0] ? {sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
    end else begin
      // sum[WIDTH] set means the trial subtraction borrowed: keep the shifted remainder
      step = sum[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                        : {sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
  end

  always_comb begin
    prod    = (sa_q ^ sb_q) ? (~acc_q + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_q;
    quo     = (sa_q ^ sb_q) ? (~acc_q[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1}) : acc_q[WIDTH-1:0];
    rem     = sa_q ? (~acc_q[2*WIDTH-1:WIDTH] + {{(WIDTH-1){1'b0}}, 1'b1})
                   : acc_q[2*WIDTH-1:WIDTH];
    fix_res = '0;
    if (op_q[2])             fix_res = op_q[1] ? rem : quo;
    else if (op_q == OP_MUL) fix_res = prod[WIDTH-1:0];
    else                     fix_res = prod[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    data_d  = data_q;
    if (i_flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_valid) begin
            op_d  = op_in;
            sa_d  = a_sgn;
            sb_d  = b_sgn;
            cnt_d = '0;
            if (op_in[2]) begin
              acc_d  = {{WIDTH{1'b0}}, a_abs};
              opnd_d = b_abs;
            end else begin
              acc_d  = {{WIDTH{1'b0}}, b_abs};
              opnd_d = a_abs;
            end
            if (div_zero || div_ovf) begin
              data_d  = special;
              state_d = S_DONE;
            end else begin
              state_d = S_CALC;
            end
          end
        end
        S_CALC: begin
          acc_d = step;
          if (cnt_q == CNT_W'(WIDTH-1)) state_d = S_FIX;
          else                          cnt_d   = cnt_q + CNT_W'(1);
        end
        S_FIX: begin
          data_d  = fix_res;
          state_d = S_DONE;
        end
        S_DONE: begin
          if (i_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      op_q    <= OP_MUL;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and random checks of muldiv_unit at WIDTH=32 and WIDTH=16 against a scoreboard.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic        v32 = 1'b0, rdy32, ov32, ir32 = 1'b0;
  logic [2:0]  op32 = '0;
  logic [31:0] a32 = '0, b32 = '0, d32;
  logic        v16 = 1'b0, rdy16, ov16, ir16 = 1'b0;
  logic [2:0]  op16 = '0;
  logic [15:0] a16 = '0, b16 = '0, d16;

  int n_pass = 0;
  int n_chk  = 0;

  typedef struct {
    logic [31:0] exp;
    string       tag;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) u_dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(v32), .o_ready(rdy32),
    .i_op(op32), .i_operandA(a32), .i_operandB(b32), .o_valid(ov32), .i_ready(ir32),
    .o_data(d32)
  );

  muldiv_unit #(.WIDTH(16)) u_dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(v16), .o_ready(rdy16),
    .i_op(op16), .i_operandA(a16), .i_operandB(b16), .o_valid(ov16), .i_ready(ir16),
    .o_data(d16)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Signed/unsigned reference for a w-bit unit; operands are taken modulo 2^w.
  function automatic logic [31:0] ref_model(input int w, input logic [2:0] op,
                                            input logic [31:0] a_in, input logic [31:0] b_in);
    longint      mask = (longint'(1) << w) - 1;
    longint      a    = {32'b0, a_in} & mask;
    longint      b    = {32'b0, b_in} & mask;
    longint      as   = ((a >> (w-1)) & 1) != 0 ? a - (longint'(1) << w) : a;
    longint      bs   = ((b >> (w-1)) & 1) != 0 ? b - (longint'(1) << w) : b;
    longint      minv = -(longint'(1) << (w-1));
    logic [63:0] pu   = a * b;
    longint      r;
    case (op)
      3'd0:    r = a * b;
      3'd1:    r = (as * bs) >>> w;
      3'd2:    r = (as * b) >>> w;
      3'd3:    r = longint'(pu >> w);
      3'd4:    r = (b == 0) ? -1 : (as == minv && bs == -1) ? as : as / bs;
      3'd5:    r = (b == 0) ? -1 : a / b;
      3'd6:    r = (b == 0) ? a  : (as == minv && bs == -1) ? 0  : as % bs;
      default: r = (b == 0) ? a  : a % b;
    endcase
    return 32'(r & mask);
  endfunction

  function automatic logic rdy(input int w);
    return (w == 32) ? rdy32 : rdy16;
  endfunction

  function automatic logic ov(input int w);
    return (w == 32) ? ov32 : ov16;
  endfunction

  function automatic logic [31:0] od(input int w);
    return (w == 32) ? d32 : {16'b0, d16};
  endfunction

  task automatic set_in(input int w, input logic v, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b);
    if (w == 32) begin
      v32 = v; op32 = op; a32 = a; b32 = b;
    end else begin
      v16 = v; op16 = op; a16 = a[15:0]; b16 = b[15:0];
    end
  endtask

  task automatic set_ir(input int w, input logic r);
    if (w == 32) ir32 = r;
    else         ir16 = r;
  endtask

  // Returns at the falling edge just after the accepting rising edge.
  task automatic issue(input int w, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit push, input logic [31:0] exp,
                       input string tag);
    int n = 0;
    @(negedge clk);
    while (!rdy(w) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rdy"}, 32'(rdy(w)), 32'd1);
    set_in(w, 1'b1, op, a, b);
    @(posedge clk);
    @(negedge clk);
    set_in(w, 1'b0, op, a, b);
    if (push) sb_q.push_back('{exp: exp, tag: tag});
  endtask

  // lat counts rising edges after the accepting edge until o_valid is seen.
  task automatic collect(input int w, output int lat);
    exp_t it;
    lat = 0;
    while (!ov(w) && lat < 200) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    it = sb_q.pop_front();
    check({it.tag, "_vld"}, 32'(ov(w)), 32'd1);
    check(it.tag, od(w), it.exp);
    set_ir(w, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_ir(w, 1'b0);
    check({it.tag, "_drop"}, 32'(ov(w)), 32'd0);
  endtask

  initial begin
    int          lat;
    logic [31:0] d0;
    bit          seen;

    #2;
    check("rst_valid", 32'(ov32), 32'd0);
    check("rst_data", d32, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready32", 32'(rdy32), 32'd1);
    check("rst_ready16", 32'(rdy16), 32'd1);

    issue(32, OP_MUL, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB, "mul_7x-3");
    collect(32, lat);
    check("mul_lat", 32'(lat), 32'd33);

    issue(32, OP_MULH, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, "mulh_min");
    collect(32, lat);
    issue(32, OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, "mulhu_max");
    collect(32, lat);
    issue(32, OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 1'b1, 32'hFFFF_FFFF, "mulhsu_neg");
    collect(32, lat);

    issue(32, OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, "div_-7/2");
    collect(32, lat);
    issue(32, OP_REM, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, "rem_-7%2");
    collect(32, lat);
    issue(32, OP_DIVU, 32'd100, 32'd7, 1'b1, 32'd14, "divu_100/7");
    collect(32, lat);
    issue(32, OP_REMU, 32'd100, 32'd7, 1'b1, 32'd2, "remu_100%7");
    collect(32, lat);

    // Special cases finish without CALC: o_valid is already up in the cycle after accept
    issue(32, OP_DIVU, 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, "divu_by0");
    collect(32, lat);
    check("divu_by0_lat", 32'(lat), 32'd0);
    issue(32, OP_REM, 32'd5, 32'd0, 1'b1, 32'd5, "rem_by0");
    collect(32, lat);
    issue(32, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, "div_ovf");
    collect(32, lat);
    check("div_ovf_lat", 32'(lat), 32'd0);

    // Flush during the 10th CALC cycle
    issue(32, OP_MUL, 32'd5, 32'd6, 1'b0, 32'd0, "flush_mul");
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check("flush_idle", 32'(rdy32), 32'd1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ov32) seen = 1'b1;
    end
    check("flush_no_valid", 32'(seen), 32'd0);
    issue(32, OP_MUL, 32'd3, 32'd4, 1'b1, 32'd12, "mul_after_flush");
    collect(32, lat);

    // Back-pressure in DONE
    issue(32, OP_DIVU, 32'd1000, 32'd3, 1'b1, 32'd333, "bp_divu");
    lat = 0;
    while (!ov32 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    d0 = d32;
    repeat (5) begin
      @(negedge clk);
      check("bp_data", d32, d0);
      check("bp_ready", 32'(rdy32), 32'd0);
      check("bp_valid", 32'(ov32), 32'd1);
    end
    collect(32, lat);

    // Asynchronous reset mid-CALC
    issue(32, OP_DIV, 32'd1234, 32'd5, 1'b0, 32'd0, "rst_div");
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(ov32), 32'd0);
    check("midrst_data", d32, 32'd0);
    check("midrst_ready", 32'(rdy32), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ov32) seen = 1'b1;
    end
    check("midrst_no_valid", 32'(seen), 32'd0);

    // Random sweep on both widths, including zero divisors and MIN/-1
    for (int k = 0; k < 2; k++) begin
      int w = (k == 0) ? 32 : 16;
      for (int i = 0; i < 40; i++) begin
        logic [2:0]  op = 3'($urandom_range(0, 7));
        logic [31:0] a  = $urandom;
        logic [31:0] b  = $urandom;
        if (i % 6 == 0) b = 32'(i % 4);
        if (i % 9 == 0) begin
          a = 32'd1 << (w - 1);
          b = '1;
        end
        issue(w, op, a, b, 1'b1, ref_model(w, op, a, b), $sformatf("sw%0d_%0d_op%0d", w, i, op));
        collect(w, lat);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
